v_rx_text: RTL and testbench
============================

Name: v_rx_text

Overview:
Receive-side counterpart of the text TX chunk path. Parses a framed chunk stream from the UART byte receiver: type byte, size byte, then size payload bytes. A chunk whose type matches INTERFACE_RX_CHUNK_TYPE and whose size fits is committed to a stable text buffer. The consumer, the min-OS text/display logic, sees a valid level and acknowledges.

Parameters:
INTERFACE_RX_CHUNK_TYPE, 5, chunk type byte accepted as text
TEXT_BUFFER_BYTE_SIZE, 33, buffer size in bytes; payload capacity = TEXT_BUFFER_BYTE_SIZE-1 (32)
TEXT_BUFFER_INDEX_SIZE, 8, bits for size/index fields
TIMEOUT_CYCLES, 120000, inter-byte timeout in CLK cycles (10 ms at 12 MHz); used only with the optional feature

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
ack  input  1  consumer has taken the committed text
text_valid  output  1  high while committed text is unacknowledged
text_size  output  TEXT_BUFFER_INDEX_SIZE  committed payload length
text_bytes  output  (TEXT_BUFFER_BYTE_SIZE-1)*8  committed payload; byte i at [8*i+7:8*i]
rx_error  output  1  one-cycle pulse on oversize, overrun or timeout
busy  output  1  high in S_SIZE, S_PAYLOAD, S_DISCARD

Behaviour:
- Clock is CLK. Reset is reset: synchronous, active-high. Reset forces state S_IDLE and clears work and committed registers, the counters and rx_error. Outputs after reset: text_valid=0, text_size=0, text_bytes=0, rx_error=0, busy=0.
- Registers:
  - work buffer and work size (receiving)
  - committed buffer and committed size (drive text_bytes and text_size)
  - byte index idx, remaining count rem
- Committed outputs change only when entering S_READY. They hold across later receptions and rejected chunks.
- States and transitions, all on a rx_valid cycle unless noted:
  - S_IDLE:
    - rx_data == INTERFACE_RX_CHUNK_TYPE -> S_SIZE, tag=accept.
    - any other value -> S_SIZE, tag=discard.
  - S_SIZE: rem <= rx_data, idx <= 0, work buffer cleared to 0.
    - tag=discard, size 0 -> S_IDLE.
    - tag=discard, size >0 -> S_DISCARD.
    - tag=accept, size > TEXT_BUFFER_BYTE_SIZE-1 -> S_DISCARD and rx_error pulse.
    - tag=accept, size 0 -> S_COMMIT.
    - tag=accept, otherwise -> S_PAYLOAD.
  - S_PAYLOAD: work[idx] <= rx_data, idx++, rem--. When rem==1 on this byte -> S_COMMIT.
  - S_DISCARD: rem-- per byte. When rem==1 -> S_IDLE.
  - S_COMMIT (no rx_valid needed): copy work buffer and size to committed -> S_READY. text_valid rises the cycle after S_COMMIT, i.e. 2 cycles after the last payload strobe.
  - S_READY: text_valid=1. ack -> S_IDLE next cycle; text_valid low that cycle.
- Overrun: rx_valid in S_COMMIT or S_READY drops the byte and pulses rx_error. This applies even if ack is asserted the same cycle; ack is still honoured.
- ack outside S_READY is ignored.
- Size arithmetic is unsigned 8-bit, so sizes up to 255 are skipped correctly in S_DISCARD. Index never exceeds capacity-1.
- Bytes at or beyond text_size in the committed buffer are 0.
- rx_error is a single-cycle pulse. Multiple error causes in one cycle give one pulse.

Optional Feature:
- Macro V_RX_TEXT_TIMEOUT_EN.
- Defined:
  - Counter active in S_SIZE, S_PAYLOAD, S_DISCARD; zeroed on every rx_valid and on state entry.
  - At TIMEOUT_CYCLES-1 without a byte: go to S_IDLE, pulse rx_error, committed outputs untouched.
- Undefined: no counter. The FSM waits indefinitely for bytes; TIMEOUT_CYCLES is unused.

Test Plan:
- Chunk 0x05,0x03,'a','b','c' -> text_valid 2 cycles after the 'c' strobe; text_size=3; text_bytes[23:0]=0x636261, upper bits 0; ack -> text_valid=0 next cycle.
- Chunk 0x07,0x02,0x41,0x42 then 0x05,0x01,0x5A -> first chunk ignored, no rx_error; committed text_size=1, text_bytes[7:0]=0x5A.
- Chunk 0x05,0x28 plus 40 bytes, then a valid 1-byte chunk -> rx_error pulse on the size byte; 40 bytes skipped; previous committed text unchanged; following chunk accepted.
- Chunk 0x05,0x00 -> text_valid with text_size=0 and text_bytes=0.
- While text_valid=1, send byte 0x05 with ack in the same cycle -> byte dropped, one rx_error pulse, S_IDLE; next full chunk received correctly.
- Reset mid-payload after 2 of 5 bytes -> all outputs 0, S_IDLE; new chunk parsed from its type byte. With V_RX_TEXT_TIMEOUT_EN and TIMEOUT_CYCLES=16, stall 16 cycles mid-payload -> rx_error, busy=0.

Source files
------------

// File: rtl/v_rx_text.sv
// Framed text-chunk receiver: type byte, size byte, payload; accepted chunks are
// committed to a stable buffer held until acked. Optional inter-byte timeout: V_RX_TEXT_TIMEOUT_EN.
module v_rx_text #(
  parameter int unsigned INTERFACE_RX_CHUNK_TYPE = 5,
  parameter int unsigned TEXT_BUFFER_BYTE_SIZE   = 33,
  parameter int unsigned TEXT_BUFFER_INDEX_SIZE  = 8,
  parameter int unsigned TIMEOUT_CYCLES          = 120000
) (
  input  logic                                 CLK,
  input  logic                                 reset,
  input  logic [7:0]                           rx_data,
  input  logic                                 rx_valid,
  input  logic                                 ack,
  output logic                                 text_valid,
  output logic [TEXT_BUFFER_INDEX_SIZE-1:0]    text_size,
  output logic [(TEXT_BUFFER_BYTE_SIZE-1)*8-1:0] text_bytes,
  output logic                                 rx_error,
  output logic                                 busy
);
  localparam int unsigned CAP = TEXT_BUFFER_BYTE_SIZE - 1;
  localparam int unsigned SW  = TEXT_BUFFER_INDEX_SIZE;
  localparam int unsigned IW  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam logic [7:0]    TYPE_B = 8'(INTERFACE_RX_CHUNK_TYPE);
  localparam logic [SW-1:0] CAP_SZ = SW'(CAP);

  typedef enum logic [2:0] {S_IDLE, S_SIZE, S_PAYLOAD, S_DISCARD, S_COMMIT, S_READY} state_t;

  state_t                 state_q, state_d;
  logic                   tag_q, tag_d;
  logic [SW-1:0]          rem_q, rem_d, idx_q, idx_d;
  logic [SW-1:0]          wsize_q, wsize_d, csize_q, csize_d;
  logic [CAP-1:0][7:0]    work_q, work_d, cbuf_q, cbuf_d;
  logic                   err_q, err_d, valid_q, valid_d, busy_q, busy_d;

`ifdef V_RX_TEXT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    wsize_d = wsize_q;
    csize_d = csize_q;
    work_d  = work_q;
    cbuf_d  = cbuf_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: if (rx_valid) begin
        tag_d   = (rx_data == TYPE_B);
        state_d = S_SIZE;
      end
      S_SIZE: if (rx_valid) begin
        rem_d   = SW'(rx_data);
        wsize_d = SW'(rx_data);
        idx_d   = '0;
        work_d  = '0;
        if (!tag_q)                      state_d = (rx_data == 8'd0) ? S_IDLE : S_DISCARD;
        else if (SW'(rx_data) > CAP_SZ) begin
          state_d = S_DISCARD;
          err_d   = 1'b1;
        end
        else if (rx_data == 8'd0)        state_d = S_COMMIT;
        else                             state_d = S_PAYLOAD;
      end
      S_PAYLOAD: if (rx_valid) begin
        work_d[idx_q[IW-1:0]] = rx_data;
        idx_d = idx_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == SW'(1)) state_d = S_COMMIT;
      end
      S_DISCARD: if (rx_valid) begin
        rem_d = rem_q - 1'b1;
        if (rem_q == SW'(1)) state_d = S_IDLE;
      end
      S_COMMIT: begin
        cbuf_d  = work_q;
        csize_d = wsize_q;
        state_d = S_READY;
        err_d   = rx_valid;
      end
      S_READY: begin
        err_d = rx_valid;  // overrun byte is dropped but ack still honoured
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef V_RX_TEXT_TIMEOUT_EN
    tmo_d = '0;
    if (state_q inside {S_SIZE, S_PAYLOAD, S_DISCARD} && !rx_valid) begin
      if (tmo_q == TMO_MAX) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
`endif

    valid_d = (state_d == S_READY);
    busy_d  = (state_d inside {S_SIZE, S_PAYLOAD, S_DISCARD});
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      tag_q   <= 1'b0;
      rem_q   <= '0;
      idx_q   <= '0;
      wsize_q <= '0;
      csize_q <= '0;
      work_q  <= '0;
      cbuf_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef V_RX_TEXT_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      wsize_q <= wsize_d;
      csize_q <= csize_d;
      work_q  <= work_d;
      cbuf_q  <= cbuf_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
`ifdef V_RX_TEXT_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign text_valid = valid_q;
  assign text_size  = csize_q;
  assign text_bytes = cbuf_q;
  assign rx_error   = err_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_v_rx_text.sv
// Directed + randomized chunk stream checked against a chunk-level reference model.
module tb_v_rx_text;
  logic         CLK = 1'b0;
  logic         reset, rx_valid, ack;
  logic [7:0]   rx_data;
  logic         text_valid, rx_error, busy;
  logic [7:0]   text_size;
  logic [255:0] text_bytes;

  int vectors = 0, miscompares = 0;
  int err_cnt = 0, exp_err = 0;
  logic [7:0]   m_size;
  logic [255:0] m_bytes;

  always #5 CLK = ~CLK;

  v_rx_text #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .ack(ack),
    .text_valid(text_valid), .text_size(text_size), .text_bytes(text_bytes),
    .rx_error(rx_error), .busy(busy));

  always @(negedge CLK) if (rx_error === 1'b1) err_cnt++;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  // Chunk-level model: only an accepted, fitting chunk replaces the committed text.
  task automatic send_chunk(input logic [7:0] typ, input logic [7:0] sz, input int gap);
    logic [255:0] pl;
    pl = '0;
    send(typ);
    send(sz);
    for (int i = 0; i < sz; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (i < 32) pl[8*i +: 8] = b;
      for (int g = 0; g < gap; g++) tick();
      send(b);
    end
    if (typ == 8'd5 && sz > 8'd32) exp_err++;
    if (typ == 8'd5 && sz <= 8'd32) begin
      m_size = sz; m_bytes = pl;
    end
  endtask

  task automatic expect_commit(input string tag);
    int n = 0;
    while (text_valid !== 1'b1 && n < 8) begin tick(); n++; end
    check({tag, "_valid"}, 256'(text_valid), 256'(1));
    check({tag, "_size"}, 256'(text_size), 256'(m_size));
    check({tag, "_bytes"}, text_bytes, m_bytes);
    do_ack();
    check({tag, "_ackd"}, 256'(text_valid), 256'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; ack = 1'b0;
    m_size = '0; m_bytes = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("rst_valid", 256'(text_valid), 256'(0));
    check("rst_size", 256'(text_size), 256'(0));
    check("rst_bytes", text_bytes, 256'(0));
    check("rst_err", 256'(rx_error), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));

    // abc chunk: exact two-cycle latency after the last strobe
    send(8'h05);
    check("busy_size", 256'(busy), 256'(1));
    send(8'h03); send(8'h61); send(8'h62); send(8'h63);
    check("abc_early", 256'(text_valid), 256'(0));
    tick();
    check("abc_valid", 256'(text_valid), 256'(1));
    check("abc_size", 256'(text_size), 256'(3));
    check("abc_bytes", text_bytes, 256'h636261);
    check("abc_busy", 256'(busy), 256'(0));
    do_ack();
    check("abc_ack", 256'(text_valid), 256'(0));

    // foreign chunk ignored silently, then 1-byte chunk
    send(8'h07); send(8'h02); send(8'h41); send(8'h42);
    tick(); tick();
    check("foreign_valid", 256'(text_valid), 256'(0));
    send(8'h05); send(8'h01); send(8'h5A);
    tick();
    check("z_valid", 256'(text_valid), 256'(1));
    check("z_size", 256'(text_size), 256'(1));
    check("z_bytes", text_bytes, 256'h5A);
    check("z_err", 256'(err_cnt), 256'(exp_err));
    do_ack();

    // oversize chunk: one error, payload skipped, committed text held
    send(8'h05); send(8'h28); exp_err++;
    tick();
    check("over_err", 256'(err_cnt), 256'(exp_err));
    for (int i = 0; i < 40; i++) send(8'h05);
    tick();
    check("over_valid", 256'(text_valid), 256'(0));
    check("over_size", 256'(text_size), 256'(1));
    check("over_bytes", text_bytes, 256'h5A);
    send(8'h05); send(8'h01); send(8'h33);
    m_size = 8'd1; m_bytes = 256'h33;
    expect_commit("after_over");

    // zero-length chunk
    send(8'h05); send(8'h00);
    tick();
    check("zero_valid", 256'(text_valid), 256'(1));
    check("zero_size", 256'(text_size), 256'(0));
    check("zero_bytes", text_bytes, 256'(0));

    // overrun together with ack
    rx_data = 8'h05; rx_valid = 1'b1; ack = 1'b1;
    tick();
    rx_valid = 1'b0; ack = 1'b0; exp_err++;
    check("ovr_valid", 256'(text_valid), 256'(0));
    check("ovr_busy", 256'(busy), 256'(0));
    tick();
    check("ovr_err", 256'(err_cnt), 256'(exp_err));
    send(8'h05); send(8'h02); send(8'h68); send(8'h69);
    m_size = 8'd2; m_bytes = 256'h6968;
    expect_commit("after_ovr");

    // reset mid-payload
    send(8'h05); send(8'h05); send(8'h01); send(8'h02);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_valid", 256'(text_valid), 256'(0));
    check("mid_size", 256'(text_size), 256'(0));
    check("mid_bytes", text_bytes, 256'(0));
    check("mid_busy", 256'(busy), 256'(0));
    check("mid_err", 256'(rx_error), 256'(0));
    send(8'h05); send(8'h01); send(8'h77);
    m_size = 8'd1; m_bytes = 256'h77;
    expect_commit("after_rst");

`ifdef V_RX_TEXT_TIMEOUT_EN
    send(8'h05); send(8'h04); send(8'h11);
    for (int i = 0; i < 16; i++) tick();
    exp_err++;
    check("tmo_busy", 256'(busy), 256'(0));
    tick();
    check("tmo_err", 256'(err_cnt), 256'(exp_err));
    check("tmo_size", 256'(text_size), 256'(m_size));
    check("tmo_bytes", text_bytes, m_bytes);
`endif

    // randomized chunks against the model
    for (int n = 0; n < 24; n++) begin
      logic [7:0] typ, sz;
      logic [7:0] old_size;
      old_size = m_size;
      typ = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(6, 255)) : 8'h05;
      sz  = 8'($urandom_range(0, 40));
      send_chunk(typ, sz, int'($urandom_range(0, 2)));
      if (typ == 8'h05 && sz <= 8'd32) begin
        expect_commit("rnd");
      end else begin
        tick(); tick();
        check("rnd_novalid", 256'(text_valid), 256'(0));
        check("rnd_hold_size", 256'(text_size), 256'(old_size));
        check("rnd_hold_bytes", text_bytes, m_bytes);
      end
      check("rnd_err", 256'(err_cnt), 256'(exp_err));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
